// File: rtl/valid_ready_multichannel_fifo.sv
// Multichannel valid/ready FIFO: CHANNELS independent queues of DEPTH entries
// each, sharing one clock and one synchronous active-high reset. Each channel
// tracks occupancy with wrap-bit pointers; read data is shown combinationally
// from the head entry, so a written word is visible the cycle after its edge.
module valid_ready_multichannel_fifo #(
    parameter int WIDTH                 = 8,
    parameter int DEPTH                 = 4,
    parameter int CHANNELS              = 2,
    parameter int ALMOST_FULL_THRESHOLD = 3,
    localparam int LEVEL_WIDTH          = $clog2(DEPTH + 1)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [CHANNELS-1:0]             flush,
    input  logic [CHANNELS*WIDTH-1:0]       write_data,
    input  logic [CHANNELS-1:0]             write_valid,
    output logic [CHANNELS-1:0]             write_ready,
    output logic [CHANNELS-1:0]             write_full,
    output logic [CHANNELS-1:0]             write_almost_full,
    output logic [CHANNELS*WIDTH-1:0]       read_data,
    output logic [CHANNELS-1:0]             read_valid,
    input  logic [CHANNELS-1:0]             read_ready,
    output logic [CHANNELS-1:0]             read_empty,
    output logic [CHANNELS*LEVEL_WIDTH-1:0] level
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0] AF_LEVEL = PTR_WIDTH'(ALMOST_FULL_THRESHOLD);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
        logic [PTR_WIDTH-1:0] wr_ptr;
        logic [PTR_WIDTH-1:0] rd_ptr;
        logic [PTR_WIDTH-1:0] count;
        logic [WIDTH-1:0]     mem [DEPTH];
        logic                 is_full;
        logic                 is_empty;
        logic                 do_write;
        logic                 do_read;

        // Equal pointers mean empty; same slot on opposite laps means full.
        assign is_empty = (wr_ptr == rd_ptr);
        assign is_full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0])
                        && (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
        assign count    = wr_ptr - rd_ptr;

        // Handshakes depend only on registered state, never on the peer's valid/ready.
        assign do_write = write_valid[c] & ~is_full;
        assign do_read  = read_ready[c] & ~is_empty;

        assign write_ready[c]       = ~is_full;
        assign write_full[c]        = is_full;
        assign write_almost_full[c] = (count >= AF_LEVEL);
        assign read_valid[c]        = ~is_empty;
        assign read_empty[c]        = is_empty;

        assign read_data[c*WIDTH +: WIDTH]             = mem[rd_ptr[ADDR_WIDTH-1:0]];
        assign level[c*LEVEL_WIDTH +: LEVEL_WIDTH]     = LEVEL_WIDTH'(count);

        // Pointer update: reset beats flush, flush beats any transfer.
        always_ff @(posedge clock) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else if (flush[c]) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_write) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (do_read) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
        end

        // Storage is never cleared; a write lands only when it really transfers.
        always_ff @(posedge clock) begin
            if (do_write && !reset && !flush[c]) begin
                mem[wr_ptr[ADDR_WIDTH-1:0]] <= write_data[c*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_valid_ready_multichannel_fifo.sv
// Bench for valid_ready_multichannel_fifo at default parameters. A queue per
// channel holds the expected contents; directed scenarios are followed by a
// randomized run compared against those queues.
module tb_valid_ready_multichannel_fifo;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 4;
    localparam int CHANNELS = 2;
    localparam int AF       = 3;
    localparam int LW       = 3;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [CHANNELS-1:0]      flush;
    logic [CHANNELS*WIDTH-1:0] write_data;
    logic [CHANNELS-1:0]      write_valid;
    logic [CHANNELS-1:0]      write_ready;
    logic [CHANNELS-1:0]      write_full;
    logic [CHANNELS-1:0]      write_almost_full;
    logic [CHANNELS*WIDTH-1:0] read_data;
    logic [CHANNELS-1:0]      read_valid;
    logic [CHANNELS-1:0]      read_ready;
    logic [CHANNELS-1:0]      read_empty;
    logic [CHANNELS*LW-1:0]   level;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] mq [CHANNELS][$];

    valid_ready_multichannel_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .ALMOST_FULL_THRESHOLD(AF)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .write_data(write_data), .write_valid(write_valid), .write_ready(write_ready),
        .write_full(write_full), .write_almost_full(write_almost_full),
        .read_data(read_data), .read_valid(read_valid), .read_ready(read_ready),
        .read_empty(read_empty), .level(level)
    );

    always #5 clock = ~clock;

    task automatic idle();
        reset       = 1'b0;
        flush       = '0;
        write_valid = '0;
        read_ready  = '0;
        write_data  = '0;
    endtask

    // One clock edge; the reference queues absorb whatever transfers the inputs request.
    task automatic cycle();
        @(posedge clock);
        for (int c = 0; c < CHANNELS; c++) begin
            if (reset || flush[c]) begin
                mq[c].delete();
            end else begin
                bit do_wr;
                bit do_rd;
                do_wr = write_valid[c] && (mq[c].size() < DEPTH);
                do_rd = read_ready[c] && (mq[c].size() > 0);
                if (do_rd) void'(mq[c].pop_front());
                if (do_wr) mq[c].push_back(write_data[c*WIDTH +: WIDTH]);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_cmp++; if (write_ready !== 2'b11) begin n_bad++; $display("FAIL reset_write_ready: got %b expected 11", write_ready); end
        n_cmp++; if (write_full !== 2'b00) begin n_bad++; $display("FAIL reset_write_full: got %b expected 00", write_full); end
        n_cmp++; if (write_almost_full !== 2'b00) begin n_bad++; $display("FAIL reset_almost_full: got %b expected 00", write_almost_full); end
        n_cmp++; if (read_valid !== 2'b00) begin n_bad++; $display("FAIL reset_read_valid: got %b expected 00", read_valid); end
        n_cmp++; if (read_empty !== 2'b11) begin n_bad++; $display("FAIL reset_read_empty: got %b expected 11", read_empty); end
        n_cmp++; if (level !== 6'd0) begin n_bad++; $display("FAIL reset_level: got %h expected 0", level); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            write_valid = 2'b01;
            write_data[7:0] = 8'(8'hA1 + i);
            cycle();
            n_cmp++; if (level[2:0] !== 3'(i + 1)) begin n_bad++; $display("FAIL fill_level0: got %0d expected %0d", level[2:0], i + 1); end
            n_cmp++; if (write_almost_full[0] !== (i + 1 >= 3)) begin n_bad++; $display("FAIL fill_almost_full0: got %b expected %b", write_almost_full[0], (i + 1 >= 3)); end
            n_cmp++; if (write_full[0] !== (i + 1 == 4)) begin n_bad++; $display("FAIL fill_full0: got %b expected %b", write_full[0], (i + 1 == 4)); end
            n_cmp++; if (write_ready[0] !== (i + 1 != 4)) begin n_bad++; $display("FAIL fill_ready0: got %b expected %b", write_ready[0], (i + 1 != 4)); end
            n_cmp++; if (read_empty[1] !== 1'b1 || level[5:3] !== 3'd0) begin n_bad++; $display("FAIL fill_ch1_idle: got empty %b level %0d expected 1 0", read_empty[1], level[5:3]); end
        end
        write_valid = 2'b00;
    endtask

    task automatic test_full_read();
        write_valid = 2'b01;
        write_data[7:0] = 8'hFF;
        read_ready = 2'b01;
        #1;
        n_cmp++; if (read_data[7:0] !== 8'hA1) begin n_bad++; $display("FAIL full_read_head: got %h expected a1", read_data[7:0]); end
        cycle();
        write_valid = 2'b00;
        n_cmp++; if (level[2:0] !== 3'd3 || write_full[0] !== 1'b0) begin n_bad++; $display("FAIL full_refuse: got level %0d full %b expected 3 0", level[2:0], write_full[0]); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (read_valid[0] !== 1'b1 || read_data[7:0] !== 8'(8'hA2 + k)) begin n_bad++; $display("FAIL full_drain: got valid %b data %h expected 1 %h", read_valid[0], read_data[7:0], 8'(8'hA2 + k)); end
            cycle();
        end
        read_ready = 2'b00;
        n_cmp++; if (read_empty[0] !== 1'b1 || level[2:0] !== 3'd0) begin n_bad++; $display("FAIL full_drain_empty: got empty %b level %0d expected 1 0", read_empty[0], level[2:0]); end
    endtask

    task automatic test_back_to_back();
        write_valid = 2'b10;
        write_data[15:8] = 8'h10;
        cycle();
        write_data[15:8] = 8'h11;
        cycle();
        n_cmp++; if (level[5:3] !== 3'd2) begin n_bad++; $display("FAIL b2b_prefill: got %0d expected 2", level[5:3]); end
        read_ready = 2'b10;
        for (int k = 0; k < 10; k++) begin
            write_data[15:8] = 8'(8'h12 + k);
            #1;
            n_cmp++; if (read_data[15:8] !== 8'(8'h10 + k)) begin n_bad++; $display("FAIL b2b_order: got %h expected %h", read_data[15:8], 8'(8'h10 + k)); end
            cycle();
            n_cmp++; if (level[5:3] !== 3'd2) begin n_bad++; $display("FAIL b2b_level: got %0d expected 2", level[5:3]); end
        end
        write_valid = 2'b00;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (read_data[15:8] !== 8'(8'h1A + k)) begin n_bad++; $display("FAIL b2b_tail: got %h expected %h", read_data[15:8], 8'(8'h1A + k)); end
            cycle();
        end
        read_ready = 2'b00;
        n_cmp++; if (read_empty[1] !== 1'b1) begin n_bad++; $display("FAIL b2b_empty: got %b expected 1", read_empty[1]); end
    endtask

    task automatic test_latency();
        idle();
        #1;
        n_cmp++; if (read_valid[0] !== 1'b0) begin n_bad++; $display("FAIL latency_pre: got %b expected 0", read_valid[0]); end
        write_valid = 2'b01;
        write_data[7:0] = 8'h5C;
        #1;
        n_cmp++; if (read_valid[0] !== 1'b0) begin n_bad++; $display("FAIL latency_fallthrough: got %b expected 0", read_valid[0]); end
        cycle();
        write_valid = 2'b00;
        n_cmp++; if (read_valid[0] !== 1'b1 || read_data[7:0] !== 8'h5C) begin n_bad++; $display("FAIL latency_post: got valid %b data %h expected 1 5c", read_valid[0], read_data[7:0]); end
        read_ready = 2'b01;
        cycle();
        read_ready = 2'b00;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            write_valid = (i < 2) ? 2'b11 : 2'b01;
            write_data  = {8'(8'h30 + i), 8'(8'h20 + i)};
            cycle();
        end
        n_cmp++; if (level !== {3'd2, 3'd3}) begin n_bad++; $display("FAIL flush_prefill: got %h expected 13", level); end
        flush = 2'b01;
        write_valid = 2'b01;
        write_data[7:0] = 8'h77;
        cycle();
        flush = 2'b00;
        write_valid = 2'b00;
        n_cmp++; if (level[2:0] !== 3'd0 || read_empty[0] !== 1'b1) begin n_bad++; $display("FAIL flush_ch0: got level %0d empty %b expected 0 1", level[2:0], read_empty[0]); end
        n_cmp++; if (level[5:3] !== 3'd2 || read_data[15:8] !== 8'h30) begin n_bad++; $display("FAIL flush_ch1_kept: got level %0d data %h expected 2 30", level[5:3], read_data[15:8]); end
    endtask

    task automatic test_reset_mid();
        write_valid = 2'b01;
        write_data[7:0] = 8'h44;
        cycle();
        reset = 1'b1;
        flush = 2'b01;
        write_valid = 2'b11;
        read_ready = 2'b11;
        write_data = 16'hBEEF;
        cycle();
        idle();
        n_cmp++; if (write_ready !== 2'b11 || write_full !== 2'b00 || write_almost_full !== 2'b00) begin n_bad++; $display("FAIL midreset_write_side: got ready %b full %b af %b expected 11 00 00", write_ready, write_full, write_almost_full); end
        n_cmp++; if (read_valid !== 2'b00 || read_empty !== 2'b11 || level !== 6'd0) begin n_bad++; $display("FAIL midreset_read_side: got valid %b empty %b level %h expected 00 11 0", read_valid, read_empty, level); end
        cycle();
        n_cmp++; if (level !== 6'd0) begin n_bad++; $display("FAIL midreset_settled: got %h expected 0", level); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 59) == 0);
            flush       = {($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0)};
            write_valid = 2'($urandom);
            read_ready  = 2'($urandom);
            write_data  = 16'($urandom);
            cycle();
            for (int c = 0; c < CHANNELS; c++) begin
                int sz;
                sz = mq[c].size();
                n_cmp++; if (level[c*LW +: LW] !== 3'(sz)) begin n_bad++; $display("FAIL rand_level ch%0d: got %0d expected %0d", c, level[c*LW +: LW], sz); end
                n_cmp++; if (write_full[c] !== (sz == DEPTH) || write_ready[c] !== (sz != DEPTH)) begin n_bad++; $display("FAIL rand_full ch%0d: got full %b ready %b expected size %0d", c, write_full[c], write_ready[c], sz); end
                n_cmp++; if (write_almost_full[c] !== (sz >= AF)) begin n_bad++; $display("FAIL rand_almost_full ch%0d: got %b expected %b", c, write_almost_full[c], (sz >= AF)); end
                n_cmp++; if (read_empty[c] !== (sz == 0) || read_valid[c] !== (sz != 0)) begin n_bad++; $display("FAIL rand_empty ch%0d: got empty %b valid %b expected size %0d", c, read_empty[c], read_valid[c], sz); end
                if (sz > 0) begin
                    n_cmp++; if (read_data[c*WIDTH +: WIDTH] !== mq[c][0]) begin n_bad++; $display("FAIL rand_data ch%0d: got %h expected %h", c, read_data[c*WIDTH +: WIDTH], mq[c][0]); end
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_fill();
        test_full_read();
        test_back_to_back();
        test_latency();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
